// File: rtl/mm_pkg.sv
// Shared matrix-multiply definitions: sequencer states, memory-select codes and size limits.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mmState_t;

  localparam logic [2:0] MEMSEL_A = 3'b000;
  localparam logic [2:0] MEMSEL_B = 3'b001;
  localparam logic [2:0] MEMSEL_C = 3'b010;

  // Largest N whose highest address N*N stays inside an 8-bit memory.
  localparam int unsigned MM_MAX_N = 15;

  localparam int unsigned ACC_W = 20;

endpackage

// File: rtl/mm_mac_acc.sv
// Multiply-accumulate register with clear, plus the C write-value stage.
// Build option MM_SATURATE_EN: clamp the write value to all-ones instead of truncating.
module mm_mac_acc
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = mm_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] aData,
  input  logic [DATA_W-1:0] bData,
  output logic [DATA_W-1:0] resultNext_c
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] accNext;

  always_comb begin
    accNext = acc + (ACC_W'(aData) * ACC_W'(bData));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= accNext;
    end
  end

  // Value of C as it will stand once the current product is folded in.
  always_comb begin
`ifdef MM_SATURATE_EN
    resultNext_c = (accNext > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : accNext[DATA_W-1:0];
`else
    resultNext_c = accNext[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/mm_mac_sequencer.sv
// Sequences the C = A*B compute pass over the shared matrix memory.
// Build option MM_SATURATE_EN selects saturating instead of truncating C values.
module mm_mac_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned ACC_W  = mm_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  size,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [IDX_W-1:0]  i,
  output logic [IDX_W-1:0]  j,
  output logic [IDX_W-1:0]  k,
  output logic [IDX_W-1:0]  max_size,
  output logic              read,
  output logic              write,
  output logic [2:0]        mem_sel,
  output logic              mac_or_size,
  output logic [DATA_W-1:0] mac_result,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mmState_t          state;
  logic [IDX_W-1:0]  lastIdx;
  logic [DATA_W-1:0] resultNext;
  logic              accClr;
  logic              accEn;

  assign lastIdx = max_size - IDX_W'(1);
  assign accEn   = (state == ACC);
  assign accClr  = (state != ACC);

  mm_mac_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) uMacAcc (
    .clk          (clk),
    .rst          (rst),
    .clr          (accClr),
    .en           (accEn),
    .aData        (a_data),
    .bData        (b_data),
    .resultNext_c (resultNext)
  );

  // Single-process FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      max_size    <= '0;
      read        <= 1'b0;
      write       <= 1'b0;
      mem_sel     <= MEMSEL_A;
      mac_or_size <= 1'b0;
      mac_result  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      read        <= 1'b0;
      write       <= 1'b0;
      mem_sel     <= MEMSEL_A;
      mac_or_size <= 1'b0;
      mac_result  <= '0;
      done        <= 1'b0;

      unique case (state)
        IDLE: begin
          // busy lingers one IDLE cycle after DONE, so starts there are ignored too.
          busy <= 1'b0;
          if (start && !busy) begin
            max_size <= size;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            busy     <= 1'b1;
            err      <= 1'b0;
            if (size == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (size > IDX_W'(MM_MAX_N)) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= ACC;
              read  <= 1'b1;
            end
          end
        end

        ACC: begin
          read <= 1'b1;
          if (j == lastIdx) begin
            // j carries k so the memory's write address lands on C[i][k].
            state      <= WRITE;
            j          <= k;
            write      <= 1'b1;
            mem_sel    <= MEMSEL_C;
            mac_result <= resultNext;
          end else begin
            j <= j + IDX_W'(1);
          end
        end

        WRITE: begin
          j <= '0;
          if (k < lastIdx) begin
            k <= k + IDX_W'(1);
          end else begin
            k <= '0;
            i <= i + IDX_W'(1);
          end
          if ((i == lastIdx) && (k == lastIdx)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ACC;
            read  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_mac_sequencer.sv
// Self-checking bench for mm_mac_sequencer with a behavioural A/B memory and matrix-product model.
module tb_mm_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] size;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic [7:0] i;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] max_size;
  logic       read;
  logic       write;
  logic [2:0] mem_sel;
  logic       mac_or_size;
  logic [7:0] mac_result;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] memA [256];
  logic [7:0] memB [256];
  int         matA [16][16];
  int         matB [16][16];

  int obsI[$];
  int obsJ[$];
  int obsK[$];
  int obsV[$];
  int obsSel[$];
  int obsMos[$];
  int doneCnt;
  int doneAt;
  int busyCnt;
  int readCnt;
  int errAtDone;

  logic [7:0] aAddr;
  logic [7:0] bAddr;

  mm_mac_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .size        (size),
    .a_data      (a_data),
    .b_data      (b_data),
    .i           (i),
    .j           (j),
    .k           (k),
    .max_size    (max_size),
    .read        (read),
    .write       (write),
    .mem_sel     (mem_sel),
    .mac_or_size (mac_or_size),
    .mac_result  (mac_result),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Memory read ports: A[i*N+j+1], B[j*N+k+1], addresses wrap at 8 bits.
  assign aAddr  = 8'(int'(i) * int'(max_size) + int'(j) + 1);
  assign bAddr  = 8'(int'(j) * int'(max_size) + int'(k) + 1);
  assign a_data = memA[aAddr];
  assign b_data = memB[bAddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expC(input int n, input int r, input int c);
    int s = 0;
    for (int x = 0; x < n; x++) s += matA[r][x] * matB[x][c];
`ifdef MM_SATURATE_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  task automatic loadMem(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        memA[r*n+c+1] = 8'(matA[r][c]);
        memB[r*n+c+1] = 8'(matB[r][c]);
      end
  endtask

  task automatic randMats(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        matA[r][c] = int'($urandom_range(0, 255));
        matB[r][c] = int'($urandom_range(0, 255));
      end
    loadMem(n);
  endtask

  // Starts a pass at the current negedge and samples every following negedge (c = cycles after accept).
  task automatic runPass(input int n, input int reAt, input int rstAt);
    int budget;
    obsI.delete(); obsJ.delete(); obsK.delete(); obsV.delete(); obsSel.delete(); obsMos.delete();
    doneCnt = 0; doneAt = -1; busyCnt = 0; readCnt = 0; errAtDone = -1;
    budget = (n >= 1 && n <= 15) ? n*n*(n+1) + 4 : 4;
    start = 1'b1;
    size  = 8'(n);
    @(posedge clk);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (rstAt != 0 && c == rstAt + 1) begin
        check("rst_idx_zero", {i, j, k, max_size}, 32'd0);
        check("rst_ctl_zero", {read, write, mem_sel, mac_or_size, mac_result, busy, done, err}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        break;
      end
      if (write) begin
        obsI.push_back(int'(i)); obsJ.push_back(int'(j)); obsK.push_back(int'(k));
        obsV.push_back(int'(mac_result)); obsSel.push_back(int'(mem_sel));
        obsMos.push_back(int'(mac_or_size));
      end
      if (done) begin
        doneCnt++;
        doneAt    = c;
        errAtDone = int'(err);
      end
      if (busy) busyCnt++;
      if (read) readCnt++;
      start = (c == reAt);
      if (c == rstAt) rst = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic verifyPass(input int n);
    bit valid = (n >= 1 && n <= 15);
    int nw    = valid ? n*n : 0;
    int lat   = valid ? n*n*(n+1) + 1 : 1;
    check("write_count", obsV.size(), nw);
    for (int e = 0; e < nw && e < obsV.size(); e++) begin
      check("write_i", obsI[e], e / n);
      check("write_j_is_k", obsJ[e], e % n);
      check("write_k", obsK[e], e % n);
      check("write_sel", obsSel[e], 2);
      check("write_mac_or_size", obsMos[e], 0);
      check("write_value", obsV[e], expC(n, e / n, e % n));
    end
    check("done_count", doneCnt, 1);
    check("done_latency", doneAt, lat);
    check("err_at_done", errAtDone, (n > 15) ? 1 : 0);
    check("busy_cycles", busyCnt, lat + 1);
    check("read_cycles", readCnt, lat - 1);
    check("err_held", err, (n > 15) ? 1 : 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    size  = '0;
    for (int x = 0; x < 256; x++) begin
      memA[x] = '0;
      memB[x] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_idx", {i, j, k, max_size}, 32'd0);
    check("reset_ctl", {read, write, mem_sel, mac_or_size, mac_result, busy, done, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // N=2 directed product
    matA[0][0] = 1; matA[0][1] = 2; matA[1][0] = 3; matA[1][1] = 4;
    matB[0][0] = 5; matB[0][1] = 6; matB[1][0] = 7; matB[1][1] = 8;
    loadMem(2);
    runPass(2, 0, 0);
    verifyPass(2);
    if (obsV.size() == 4) begin
      check("n2_c00", obsV[0], 19);
      check("n2_c01", obsV[1], 22);
      check("n2_c10", obsV[2], 43);
      check("n2_c11", obsV[3], 50);
    end else begin
      check("n2_write_count", obsV.size(), 4);
    end

    // N=1, 16*20 = 320 overflows 8 bits
    matA[0][0] = 16; matB[0][0] = 20;
    loadMem(1);
    runPass(1, 0, 0);
    verifyPass(1);
`ifdef MM_SATURATE_EN
    check("n1_value", (obsV.size() > 0) ? obsV[0] : -1, 255);
`else
    check("n1_value", (obsV.size() > 0) ? obsV[0] : -1, 64);
`endif

    // N=0: immediate done, no writes
    runPass(0, 0, 0);
    verifyPass(0);

    // N=16: rejected with err, then cleared by a valid start
    runPass(16, 0, 0);
    verifyPass(16);
    randMats(3);
    runPass(3, 0, 0);
    verifyPass(3);

    // Reset during the 5th ACC cycle of an N=3 pass (cycle 6 after accept)
    randMats(3);
    runPass(3, 0, 6);
    check("abort_writes", obsV.size(), 1);
    randMats(2);
    runPass(2, 0, 0);
    verifyPass(2);

    // start re-pulsed mid-pass is ignored
    randMats(2);
    runPass(2, 5, 0);
    verifyPass(2);

    // Random sizes including the largest legal N
    for (int t = 0; t < 3; t++) begin
      int n = int'($urandom_range(2, 6));
      randMats(n);
      runPass(n, 0, 0);
      verifyPass(n);
    end
    randMats(15);
    runPass(15, 0, 0);
    verifyPass(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_mac_sequencer.md
Name: mm_mac_sequencer

Overview:
Drives the matrix-multiply compute pass over the shared A/B/C matrix memory.
- Iterates i, k (output element) and j (reduction index).
- Reads A[i][j] and B[j][k] combinationally through the memory's outA/outB.
- Accumulates the products, then writes each C[i][k] back through the memory's MAC_Result path.
- Sits downstream of the matrix loader, which fills MemA and MemB, and upstream of the result readback.

Parameters:
- DATA_W, 8, element and memory data width.
- IDX_W, 8, width of the i/j/k/size index buses.
- ACC_W, 20, internal accumulator width (holds 15*255*255 without overflow).

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- size  in  IDX_W  matrix dimension N; latched on an accepted start.
- a_data  in  DATA_W  memory outA, which is A[i*N+j+1].
- b_data  in  DATA_W  memory outB, which is B[j*N+k+1].
- i  out  IDX_W  row index to memory.
- j  out  IDX_W  reduction index to memory; carries k during WRITE.
- k  out  IDX_W  column index to memory.
- max_size  out  IDX_W  latched N, to the memory maxSize input.
- read  out  1  memory read enable.
- write  out  1  memory write enable.
- mem_sel  out  3  memory select; 3'b010 (MemC) during WRITE, 3'b000 otherwise.
- mac_or_size  out  1  always 0 (selects the MAC_Result path).
- mac_result  out  DATA_W  value written into C.
- busy  out  1  high from the accepted start until the DONE state is left.
- done  out  1  one-cycle completion pulse.
- err  out  1  set when N > 15; held until the next accepted start or rst.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulator cleared. A reset mid-pass aborts immediately. C elements already written stay as written.
- States: IDLE, ACC, WRITE, DONE.
- IDLE:
  - On start, latch N = size, clear the accumulator and i/j/k, and set busy.
  - If N == 0, go to DONE (no writes, err = 0).
  - If N > 15, go to DONE with err = 1. Address i*N+j+1 would exceed 255.
  - Otherwise go to ACC.
  - start while busy is ignored.
- ACC:
  - read = 1 each cycle; acc <= acc + a_data*b_data (unsigned, full ACC_W).
  - j increments each cycle.
  - When j == N-1, the next state is WRITE.
- WRITE: held for exactly one cycle.
  - read = 1, write = 1, mem_sel = 3'b010, and j output = k, so the memory's write address i*N+k+1 is C[i][k].
  - mac_result = acc[DATA_W-1:0] (truncation).
  - Next, clear acc and j. If k < N-1, increment k; else set k = 0 and increment i.
  - If i == N-1 and k == N-1, go to DONE; else go to ACC.
- DONE: done = 1 for one cycle, busy drops on the following cycle, return to IDLE.
- Outside WRITE: write = 0 and mac_result = 0.
- Latency: each C element takes N+1 cycles. done is asserted N²(N+1)+1 cycles after the cycle in which start is accepted.
- Write order: C is written row-major, at addresses 1..N².

Optional Feature:
MM_SATURATE_EN
- Defined: mac_result = 8'hFF whenever acc > 255; otherwise acc[7:0].
- Undefined: plain truncation to acc[7:0].
- Only the WRITE value changes; timing is identical in both cases.

Decomposition:
- Shared package mm_pkg holds:
  - the state enum (IDLE/ACC/WRITE/DONE);
  - MEMSEL_A = 3'b000, MEMSEL_B = 3'b001, MEMSEL_C = 3'b010;
  - MM_MAX_N = 15;
  - ACC_W.
- The memory block and the loader reuse the MEMSEL constants and MM_MAX_N.
- One natural sub-module, mm_mac_acc: multiply-accumulate with a clear input, plus the truncate/saturate output stage.

Test Plan:
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> writes 19, 22, 43, 50 with j-port/k = 0,1,0,1 and i = 0,0,1,1; done exactly 13 cycles after start; err = 0.
- N=1, A=16, B=20 -> one write; mac_result = 0x40 without MM_SATURATE_EN, 0xFF with it.
- N=0 -> no write pulse; done on the cycle after start; busy high for exactly 2 cycles.
- N=16 -> no read or write; err = 1 and done on the next cycle; err clears on a following valid start.
- N=3 pass with rst asserted during the 5th ACC cycle -> all outputs 0 on the next cycle, state IDLE; a following start with N=2 yields the correct 4 writes.
- start re-pulsed while busy (N=2) -> ignored; exactly 4 writes and a single done pulse.
